// File: rtl/pll_phase_tracker.sv
// pll_phase_tracker: phase counter locked to a slow reference, with lock FSM and phase strobes
module pll_phase_tracker #(
  parameter int RATIO = 8,
  parameter int EDGE_LOAD = 1,
  parameter int LOCK_CNT = 4,
  parameter int NUM_TAPS = 2,
  localparam int CW = $clog2(RATIO)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   slw_in,
  input  logic [NUM_TAPS*CW-1:0] tap_phase,
  output logic [CW-1:0]          ctr,
  output logic [1:0]             state,
  output logic                   locked,
  output logic                   slip,
  output logic [NUM_TAPS-1:0]    tap_stb
);
  localparam int TW = $clog2(2*RATIO+1);
  localparam int GW = $clog2(LOCK_CNT+1);
  typedef enum logic [1:0] {UNLOCKED = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;
  state_t st_q, st_d;
  logic slw_prev, rise, aligned, timeout, slip_d;
  logic [CW-1:0] ctr_nf;
  logic [TW-1:0] tmo;
  logic [GW-1:0] gcnt, gcnt_d;
  logic [NUM_TAPS-1:0] hit;
  assign rise = slw_in && !slw_prev;
  assign ctr_nf = (ctr == CW'(RATIO-1)) ? '0 : ctr + CW'(1);
  assign aligned = ctr_nf == CW'(EDGE_LOAD);
  assign timeout = (tmo == TW'(2*RATIO-1)) && !rise;
  assign state = st_q;
  assign locked = st_q == LOCKED;
  for (genvar g = 0; g < NUM_TAPS; g++) begin : g_tap
    assign hit[g] = ctr == tap_phase[g*CW +: CW];
  end
  // edge detect, phase counter (reloaded on rise) and saturating rise timeout
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      slw_prev <= 1'b0;
      ctr <= '0;
      tmo <= '0;
    end else begin
      slw_prev <= slw_in;
      ctr <= rise ? CW'(EDGE_LOAD) : ctr_nf;
      tmo <= rise ? '0 : (tmo == TW'(2*RATIO)) ? tmo : tmo + TW'(1);
    end
  // lock state register, good-rise count and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q <= UNLOCKED;
      gcnt <= '0;
      slip <= 1'b0;
      tap_stb <= '0;
    end else begin
      st_q <= st_d;
      gcnt <= gcnt_d;
      slip <= slip_d;
      tap_stb <= locked ? hit : '0;
    end
  // lock FSM: acquire on consecutive aligned rises, drop on misalignment or timeout
  always_comb begin
    st_d = st_q;
    gcnt_d = gcnt;
    slip_d = 1'b0;
    case (st_q)
      UNLOCKED: if (rise) begin
        st_d = ACQUIRE;
        gcnt_d = '0;
      end
      ACQUIRE: if (rise && aligned) begin
        if (gcnt == GW'(LOCK_CNT-1)) st_d = LOCKED;
        else gcnt_d = gcnt + GW'(1);
      end else if (rise) gcnt_d = '0;
      else if (timeout) st_d = UNLOCKED;
      LOCKED: if (rise && !aligned) begin
        st_d = ACQUIRE;
        gcnt_d = '0;
        slip_d = 1'b1;
      end else if (timeout) begin
        st_d = UNLOCKED;
        slip_d = 1'b1;
      end
      default: st_d = UNLOCKED;
    endcase
  end
endmodule

// File: tb/tb_pll_phase_tracker.sv
// tb_pll_phase_tracker: randomized reference jitter/dropouts on three configurations, scoreboard vs behavioural model
module tb_pll_phase_tracker;
  localparam int N = 3;
  typedef struct {int d; int ctr; int st; int lk; int slip; int stb;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] slw = '0;
  logic [5:0] tp0, tp1;
  logic [8:0] tp2;
  logic [2:0] c0, c1, c2, t2;
  logic [1:0] s0, s1, s2, t0, t1;
  logic l0, l1, l2, p0, p1, p2;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  exp_t me;
  int m_ctr[N], m_st[N], m_g[N], m_since[N], lock_seen[N];
  bit m_prev[N];
  int tap[N][3];
  int ph[N], plen[N], clean[N];

  pll_phase_tracker #(.RATIO(8), .EDGE_LOAD(1), .LOCK_CNT(4), .NUM_TAPS(2)) u0 (
    .clk(clk), .rst_n(rst_n), .slw_in(slw[0]), .tap_phase(tp0), .ctr(c0), .state(s0),
    .locked(l0), .slip(p0), .tap_stb(t0));
  pll_phase_tracker #(.RATIO(5), .EDGE_LOAD(1), .LOCK_CNT(4), .NUM_TAPS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .slw_in(slw[1]), .tap_phase(tp1), .ctr(c1), .state(s1),
    .locked(l1), .slip(p1), .tap_stb(t1));
  pll_phase_tracker #(.RATIO(6), .EDGE_LOAD(3), .LOCK_CNT(1), .NUM_TAPS(3)) u2 (
    .clk(clk), .rst_n(rst_n), .slw_in(slw[2]), .tap_phase(tp2), .ctr(c2), .state(s2),
    .locked(l2), .slip(p2), .tap_stb(t2));

  always #5 clk = ~clk;

  function automatic int rat(int d); return d == 0 ? 8 : d == 1 ? 5 : 6; endfunction
  function automatic int eld(int d); return d == 2 ? 3 : 1; endfunction
  function automatic int lcn(int d); return d == 2 ? 1 : 4; endfunction
  function automatic int ntp(int d); return d == 2 ? 3 : 2; endfunction

  function automatic exp_t act(int d);
    exp_t a;
    a.d = d;
    a.ctr = d == 0 ? int'(c0) : d == 1 ? int'(c1) : int'(c2);
    a.st = d == 0 ? int'(s0) : d == 1 ? int'(s1) : int'(s2);
    a.lk = d == 0 ? int'(l0) : d == 1 ? int'(l1) : int'(l2);
    a.slip = d == 0 ? int'(p0) : d == 1 ? int'(p1) : int'(p2);
    a.stb = d == 0 ? int'(t0) : d == 1 ? int'(t1) : int'(t2);
    return a;
  endfunction

  task automatic chk(input string n, input int d, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s[dut%0d] got %0d expected %0d at %0t", n, d, a, e, $time);
    end
  endtask

  task automatic drive_taps();
    tp0 = {3'(tap[0][1]), 3'(tap[0][0])};
    tp1 = {3'(tap[1][1]), 3'(tap[1][0])};
    tp2 = {3'(tap[2][2]), 3'(tap[2][1]), 3'(tap[2][0])};
  endtask

  task automatic model_reset();
    for (int d = 0; d < N; d++) begin
      m_ctr[d] = 0; m_st[d] = 0; m_g[d] = 0; m_since[d] = 0; m_prev[d] = 0;
    end
  endtask

  // one clock edge of the reference behaviour, written from the requirement rules
  task automatic model_step(input int d, input bit s);
    int r, nf, stb, slp;
    bit rise, al, to;
    exp_t e;
    r = rat(d);
    rise = s && !m_prev[d];
    nf = (m_ctr[d] + 1) % r;
    al = nf == eld(d);
    to = !rise && m_since[d] == 2*r - 1;
    stb = 0;
    slp = 0;
    for (int k = 0; k < ntp(d); k++)
      if (m_st[d] == 2 && m_ctr[d] == tap[d][k]) stb |= 1 << k;
    if (m_st[d] == 0) begin
      if (rise) begin m_st[d] = 1; m_g[d] = 0; end
    end else if (m_st[d] == 1) begin
      if (rise && al) begin
        if (m_g[d] + 1 == lcn(d)) begin m_st[d] = 2; lock_seen[d]++; end
        else m_g[d]++;
      end else if (rise) m_g[d] = 0;
      else if (to) m_st[d] = 0;
    end else begin
      if (rise && !al) begin m_st[d] = 1; m_g[d] = 0; slp = 1; end
      else if (to) begin m_st[d] = 0; slp = 1; end
    end
    m_ctr[d] = rise ? eld(d) : nf;
    m_since[d] = rise ? 0 : m_since[d] + 1;
    m_prev[d] = s;
    e.d = d; e.ctr = m_ctr[d]; e.st = m_st[d]; e.lk = m_st[d] == 2; e.slip = slp; e.stb = stb;
    q.push_back(e);
  endtask

  function automatic int choose(int d);
    int r, x;
    r = rat(d);
    if (clean[d] > 0) begin clean[d]--; return r; end
    x = $urandom_range(0, 99);
    if (x < 80) return r;
    if (x < 88) return r + $urandom_range(1, 3);
    if (x < 93) return r - 1;
    return 2*r + $urandom_range(0, 2*r);
  endfunction

  task automatic gen(input int d);
    slw[d] = ph[d] < rat(d) / 2;
    ph[d]++;
    if (ph[d] == plen[d]) begin
      ph[d] = 0;
      plen[d] = choose(d);
    end
  endtask

  task automatic chk_zero(input string n);
    exp_t a;
    for (int d = 0; d < N; d++) begin
      a = act(d);
      chk({n, "_ctr"}, d, a.ctr, 0);
      chk({n, "_state"}, d, a.st, 0);
      chk({n, "_locked"}, d, a.lk, 0);
      chk({n, "_slip"}, d, a.slip, 0);
      chk({n, "_tap_stb"}, d, a.stb, 0);
    end
  endtask

  // monitor: every cycle the DUTs present outputs; compare against queued expectations
  always @(negedge clk)
    while (q.size() > 0) begin
      me = q.pop_front();
      chk("ctr", me.d, act(me.d).ctr, me.ctr);
      chk("state", me.d, act(me.d).st, me.st);
      chk("locked", me.d, act(me.d).lk, me.lk);
      chk("slip", me.d, act(me.d).slip, me.slip);
      chk("tap_stb", me.d, act(me.d).stb, me.stb);
    end

  initial begin
    tap[0][0] = 0; tap[0][1] = 3; tap[0][2] = 0;
    tap[1][0] = 2; tap[1][1] = 6; tap[1][2] = 0;
    tap[2][0] = 5; tap[2][1] = 5; tap[2][2] = 7;
    drive_taps();
    for (int d = 0; d < N; d++) begin
      ph[d] = 0; plen[d] = rat(d); clean[d] = 12; lock_seen[d] = 0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < N; d++) gen(d);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      for (int d = 0; d < N; d++) model_step(d, slw[d]);
      #1;
      for (int d = 0; d < N; d++) gen(d);
      if ($urandom_range(0, 99) < 2) begin
        tap[$urandom_range(0, 2)][$urandom_range(0, 2)] = $urandom_range(0, 7);
        drive_taps();
      end
      if (cyc == 1500) begin
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        @(posedge clk);
        #1 chk_zero("held_reset");
        #2 rst_n = 1'b1;
        model_reset();
        for (int d = 0; d < N; d++) clean[d] = 12;
      end
    end
    @(negedge clk);
    #1;
    chk("queue_drained", 0, q.size(), 0);
    for (int d = 0; d < N; d++) chk("lock_reached", d, int'(lock_seen[d] > 0), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
